// File: rtl/atm_login_ctrl_pkg.sv
// Shared definitions for the ATM login controller: FSM states, failure codes
// and the authenticator's status encodings.
package atm_login_ctrl_pkg;

  localparam int PIN_DIGITS = 4;
  localparam int PIN_W      = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GET_PIN = 3'd1,
    S_CHECK   = 3'd2,
    S_ACTIVE  = 3'd3,
    S_LOCKED  = 3'd4
  } state_t;

  localparam logic [1:0] FAIL_BAD_PIN = 2'd0;
  localparam logic [1:0] FAIL_NO_ACC  = 2'd1;
  localparam logic [1:0] FAIL_TIMEOUT = 2'd2;

  // Authenticator status levels.
  localparam logic ACCOUNT_FOUND         = 1'b1;
  localparam logic ACCOUNT_AUTHENTICATED = 1'b1;

endpackage

// File: rtl/atm_login_ctrl_pin_accumulator.sv
// Builds a binary PIN from BCD keypad digits: range filter, digit count and
// the pin*10+digit datapath.
module pin_accumulator
  import atm_login_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             digit_valid,
  input  logic [3:0]       digit,
  output logic [PIN_W-1:0] pin,
  output logic [2:0]       count,
  output logic             full,
  output logic             accept
);

  logic [PIN_W-1:0] pin_x10;

  assign full    = (count == 3'(PIN_DIGITS));
  assign accept  = en & digit_valid & (digit <= 4'd9) & ~full;
  // pin*10 as pin*8 + pin*2; four digits never exceed 9999 so 16 bits suffice.
  assign pin_x10 = {pin[PIN_W-4:0], 3'b000} + {pin[PIN_W-2:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pin   <= '0;
      count <= '0;
    end else if (clr) begin
      pin   <= '0;
      count <= '0;
    end else if (accept) begin
      pin   <= pin_x10 + {12'd0, digit};
      count <= count + 3'd1;
    end
  end

endmodule

// File: rtl/atm_login_ctrl.sv
// Card/PIN login session FSM in front of a combinational account
// authenticator; handles retries, lockout and keypad inactivity timeout.
module atm_login_ctrl
  import atm_login_ctrl_pkg::*;
#(
  parameter int MAX_ATTEMPTS   = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             card_insert,
  input  logic [3:0]       acc_num_in,
  input  logic             digit_valid,
  input  logic [3:0]       digit,
  input  logic             enter,
  input  logic             cancel,
  input  logic             admin_unlock,
  input  logic             acc_found_stat,
  input  logic             acc_auth_stat,
  input  logic [3:0]       acc_index_in,
  output logic [3:0]       acc_num,
  output logic [PIN_W-1:0] pin,
  output logic             session_active,
  output logic [3:0]       acc_index,
  output logic             login_ok,
  output logic             login_fail,
  output logic [1:0]       fail_code,
  output logic [2:0]       attempts_left,
  output logic             card_locked,
  output logic             card_eject
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    ATT_MAX  = 3'(MAX_ATTEMPTS);

  state_t        state, state_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [3:0]    acc_num_n, acc_index_n;
  logic [2:0]    att_n;
  logic [1:0]    code_n;
  logic          ok_n, fail_n, eject_n;
  logic          pin_clr, pin_en, pin_full, pin_accept;
  logic [2:0]    pin_count;

  // Digits are taken only in an undisturbed GET_PIN cycle.
  assign pin_en = (state == S_GET_PIN) & ~cancel & card_insert;

  pin_accumulator u_pin_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (pin_clr),
    .en         (pin_en),
    .digit_valid(digit_valid),
    .digit      (digit),
    .pin        (pin),
    .count      (pin_count),
    .full       (pin_full),
    .accept     (pin_accept)
  );

  always_comb begin
    state_n     = state;
    tmr_n       = '0;
    acc_num_n   = acc_num;
    acc_index_n = acc_index;
    att_n       = attempts_left;
    code_n      = FAIL_BAD_PIN;
    ok_n        = 1'b0;
    fail_n      = 1'b0;
    eject_n     = 1'b0;
    pin_clr     = 1'b0;
    case (state)
      S_IDLE: begin
        if (card_insert) begin
          acc_num_n = acc_num_in;
          pin_clr   = 1'b1;
          att_n     = ATT_MAX;
          state_n   = S_GET_PIN;
        end
      end
      S_GET_PIN: begin
        if (cancel) begin
          eject_n = 1'b1;
          state_n = S_IDLE;
        end else if (!card_insert) begin
          state_n = S_IDLE;
        end else if (enter && pin_full && !digit_valid) begin
          state_n = S_CHECK;
        end else if (!pin_accept && !enter) begin
          if (tmr == TMR_LAST) begin
            fail_n  = 1'b1;
            code_n  = FAIL_TIMEOUT;
            eject_n = 1'b1;
            state_n = S_IDLE;
          end else begin
            tmr_n = tmr + TW'(1);
          end
        end
      end
      S_CHECK: begin
        if (acc_found_stat != ACCOUNT_FOUND) begin
          fail_n  = 1'b1;
          code_n  = FAIL_NO_ACC;
          eject_n = 1'b1;
          state_n = S_IDLE;
        end else if (acc_auth_stat == ACCOUNT_AUTHENTICATED) begin
          acc_index_n = acc_index_in;
          ok_n        = 1'b1;
          state_n     = S_ACTIVE;
        end else begin
          att_n   = attempts_left - 3'd1;
          fail_n  = 1'b1;
          code_n  = FAIL_BAD_PIN;
          pin_clr = 1'b1;
          // Last attempt used: keep the card and wait for an operator.
          state_n = (attempts_left == 3'd1) ? S_LOCKED : S_GET_PIN;
        end
      end
      S_ACTIVE: begin
        if (cancel) begin
          eject_n = 1'b1;
          state_n = S_IDLE;
        end else if (!card_insert) begin
          state_n = S_IDLE;
        end
      end
      S_LOCKED: begin
        if (admin_unlock) begin
          eject_n = 1'b1;
          att_n   = ATT_MAX;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      tmr            <= '0;
      acc_num        <= '0;
      acc_index      <= '0;
      attempts_left  <= ATT_MAX;
      fail_code      <= FAIL_BAD_PIN;
      login_ok       <= 1'b0;
      login_fail     <= 1'b0;
      card_eject     <= 1'b0;
      session_active <= 1'b0;
      card_locked    <= 1'b0;
    end else begin
      state          <= state_n;
      tmr            <= tmr_n;
      acc_num        <= acc_num_n;
      acc_index      <= acc_index_n;
      attempts_left  <= att_n;
      fail_code      <= code_n;
      login_ok       <= ok_n;
      login_fail     <= fail_n;
      card_eject     <= eject_n;
      session_active <= (state_n == S_ACTIVE);
      card_locked    <= (state_n == S_LOCKED);
    end
  end

endmodule

// File: doc/atm_login_ctrl.md
Name: atm_login_ctrl

Overview:
Sequential front-end that runs the card/PIN login session and feeds the combinational account authenticator directly downstream of it. On card insertion it does three things: latches the account number, assembles four keypad digits into a binary PIN value, and presents both to the authenticator. It samples the found/authenticated verdict, enforces a retry limit with card lockout and a keypad inactivity timeout, and hands the authenticated account index to the transaction logic.

Parameters:
MAX_ATTEMPTS, 3, wrong-PIN attempts allowed per card before lockout (1..7)
TIMEOUT_CYCLES, 1000, idle clocks in PIN entry before the session is aborted (>=2)
PIN_DIGITS, 4, decimal digits per PIN (fixed at 4; PIN value <= 9999)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
card_insert  in  1  level; card present in slot
acc_num_in  in  4  account number read from card
digit_valid  in  1  one-cycle strobe, keypad digit present
digit  in  4  keypad digit, BCD
enter  in  1  one-cycle strobe, PIN entry complete
cancel  in  1  one-cycle strobe, user abort or logout
admin_unlock  in  1  one-cycle strobe, releases a locked card
acc_found_stat  in  1  from authenticator, `ACCOUNT_FOUND when matched
acc_auth_stat  in  1  from authenticator, `ACCOUNT_AUTHENTICATED when PIN matches
acc_index_in  in  4  from authenticator, matched DB index
acc_num  out  4  registered account number to authenticator
pin  out  16  registered binary PIN value to authenticator
session_active  out  1  high while in ACTIVE
acc_index  out  4  latched index of the logged-in account
login_ok  out  1  one-cycle pulse on successful login
login_fail  out  1  one-cycle pulse on any failed check or timeout
fail_code  out  2  valid with login_fail: 0 bad PIN, 1 no account, 2 timeout
attempts_left  out  3  remaining PIN attempts
card_locked  out  1  high while in LOCKED
card_eject  out  1  one-cycle pulse commanding card return

Behaviour:
- Reset (async, rst_n=0): state IDLE. acc_num=0, pin=0, acc_index=0, attempts_left=MAX_ATTEMPTS, all pulses and levels 0, digit count 0, timeout counter 0.
- State register and all outputs are flops; every output is registered.
- IDLE: when card_insert=1, latch acc_num_in into acc_num, clear pin and digit count, set attempts_left=MAX_ATTEMPTS, go to GET_PIN.
- GET_PIN, in priority order per cycle:
  - cancel: pulse card_eject and go to IDLE.
  - digit_valid with digit<=9 and count<4: pin <= pin*10 + digit (16-bit arithmetic), count+1.
  - digit>9, or a fifth or later digit: ignored.
  - enter with count==4 and no digit_valid in the same cycle: go to CHECK.
  - enter otherwise: ignored.
  - Timeout counter clears on any accepted digit or enter and increments otherwise. On reaching TIMEOUT_CYCLES-1: pulse login_fail with fail_code=2, pulse card_eject, go to IDLE.
- CHECK (exactly one cycle; the authenticator is combinational on the registered acc_num/pin):
  - acc_found_stat != FOUND: pulse login_fail with fail_code=1, pulse card_eject, go to IDLE. attempts_left is not charged.
  - found and authenticated: latch acc_index_in into acc_index, pulse login_ok, go to ACTIVE.
  - found and not authenticated: attempts_left-1, pulse login_fail with fail_code=0, clear pin and count.
    - New attempts_left==0: go to LOCKED; card_eject is not pulsed and the card is retained.
    - Otherwise: return to GET_PIN.
- Latency: enter strobe to login_ok/login_fail is 2 clocks (enter accepted at edge N, CHECK at N+1, pulse visible after edge N+1).
- ACTIVE: session_active=1. cancel pulses card_eject and goes to IDLE. acc_index holds until the next successful login.
- LOCKED: card_locked=1. All keypad inputs are ignored. admin_unlock pulses card_eject, restores attempts_left=MAX_ATTEMPTS, and goes to IDLE.
- card_insert low in GET_PIN or ACTIVE: treated as cancel, except that card_eject is not pulsed.
- cancel in CHECK: ignored; the verdict completes first.

Decomposition:
- definitions.v (shared include) gets: state encodings (IDLE, GET_PIN, CHECK, ACTIVE, LOCKED), fail_code values, and reuse of `ACCOUNT_FOUND / `ACCOUNT_AUTHENTICATED.
- One natural sub-module, pin_accumulator. It contains the digit count, the *10+digit datapath, digit-range filtering, and clear/full flags; the FSM owns everything else.

Test Plan:
- Acc 1, digits 1,2,3,4, enter, authenticator stub says found+auth, index 0 -> pin=1234 (0x04D2) at CHECK; login_ok 2 clocks after enter; session_active=1; acc_index=0.
- Acc 2, wrong PIN three times (1,1,1,1) -> login_fail with fail_code=0 and attempts_left 2,1,0; then card_locked=1, no card_eject; admin_unlock -> card_eject, IDLE, attempts_left=3.
- Acc 12 with stub not found -> login_fail fail_code=1 and card_eject one cycle after the CHECK edge; attempts_left stays 3.
- Digits 9,A,8,7,6,5 with enter after 3 digits -> A and 5 ignored, first enter ignored, pin=9876 after the fourth valid digit; a later enter proceeds to CHECK.
- TIMEOUT_CYCLES=8, card inserted, one digit then silence -> after 8 idle cycles login_fail fail_code=2 and card_eject; state IDLE.
- rst_n asserted mid-GET_PIN with pin=12 -> outputs clear immediately without a clock edge; attempts_left=3.
